mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
//  Multi-cycle main control FSM for the MIPS core. Decodes the 6-bit opcode
//  and sequences the datapath one step per clock.
//  It is the producer of the 2-bit AluOp consumed by the ALU control decoder:
//  00 = add (address / PC+4), 01 = subtract (beq), 10 = use funct field.
//  It never drives AluOp = 11.
//  It stalls on instruction and data memory accesses until mem_ready is high.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
//  clk         in   1  clock, all state updates on rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  opcode      in   6  instr[31:26] from the instruction register
//  mem_ready   in   1  memory has completed the current read or write this cycle
//  pc_write    out  1  unconditional PC load
//  pc_wr_cond  out  1  PC load if ALU zero (beq)
//  i_or_d      out  1  memory address: 0 = PC, 1 = ALUOut
//  mem_read    out  1  memory read request
//  mem_write   out  1  memory write request
//  ir_write    out  1  load instruction register
//  mem_to_reg  out  1  register writeback source: 0 = ALUOut, 1 = MDR
//  reg_dst     out  1  destination register: 0 = rt, 1 = rd
//  reg_write   out  1  register file write enable
//  alu_src_a   out  1  ALU A input: 0 = PC, 1 = register A
//  alu_src_b   out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
//  alu_op      out  2  to ALU control decoder (encoding above)
//  pc_source   out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
//  illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
// BEHAVIOUR
//  Reset
//   - rst_n low → state = RST immediately (asynchronous); every output is 0.
//   - RST → FETCH on the first clk edge with rst_n high.
//   - rst_n low in any state, including mid-stall, aborts the instruction.
//     No mem_write or reg_write may be asserted on the edge following reset release.
//  Opcodes
//   - R = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, j = 000010.
//  Outputs
//   - Outputs are a pure decode of state (Moore).
//   - Exception: in FETCH, ir_write and pc_write are gated with mem_ready (rdy),
//     so each fetch loads IR and PC exactly once.
//   - Unlisted outputs are 0 in every state.
//  States (outputs asserted -> next state)
//   - RST     : none -> FETCH
//   - FETCH   : mem_read, alu_op = 00, alu_src_b = 01, ir_write & rdy, pc_write & rdy
//               -> DECODE if rdy, else stay in FETCH
//   - DECODE  : alu_op = 00, alu_src_b = 11 (branch target into ALUOut)
//               -> lw/sw: MEMADR; R: EXEC; beq: BRANCH; addi: ADDIEX; j: JUMP;
//                  other: FETCH with illegal_op = 1 for this cycle only
//   - MEMADR  : alu_src_a = 1, alu_src_b = 10, alu_op = 00 -> lw: MEMRD; sw: MEMWR
//   - MEMRD   : mem_read, i_or_d -> MEMWB if rdy, else stay
//   - MEMWB   : reg_write, mem_to_reg, reg_dst = 0 -> FETCH
//   - MEMWR   : mem_write, i_or_d -> FETCH if rdy, else stay
//   - EXEC    : alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> RWB
//   - RWB     : reg_write, reg_dst = 1, mem_to_reg = 0 -> FETCH
//   - BRANCH  : alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_wr_cond, pc_source = 01 -> FETCH
//   - ADDIEX  : alu_src_a = 1, alu_src_b = 10, alu_op = 00 -> ADDIWB
//   - ADDIWB  : reg_write, reg_dst = 0, mem_to_reg = 0 -> FETCH
//   - JUMP    : pc_write, pc_source = 10 -> FETCH
//  Timing and stalls
//   - Cycle counts with mem_ready tied high:
//     R 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.
//   - While stalled, the request outputs (mem_read / mem_write / i_or_d)
//     hold stable and no other write enable is asserted.
//   - opcode is sampled only in DECODE and MEMADR; the IR must hold it stable from FETCH on.
//   - Encode state in 4 bits. Any unreachable encoding → FETCH on the next edge,
//     with all outputs 0 while in it.
// TESTING
//  1. rst_n = 0 mid-MEMRD with mem_ready = 0 → all outputs 0 at once;
//     release → RST, then FETCH on the next edge; mem_read = 1.
//  2. opcode 000000, mem_ready = 1 → states FETCH, DECODE, EXEC, RWB;
//     alu_op = 10 only in EXEC; reg_write = 1, reg_dst = 1 only in RWB.
//  3. lw (100011), mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles,
//     i_or_d = 1 throughout, reg_write = 0 until MEMWB.
//  4. beq (000100) → alu_op = 01 and pc_wr_cond = 1 for exactly one cycle;
//     alu_op never equals 11 over a 1000-instruction random opcode run.
//  5. opcode 111111 → illegal_op pulses for 1 cycle in DECODE, back to FETCH,
//     no reg_write or mem_write asserted.
//  6. FETCH with mem_ready low 2 cycles, then high → ir_write and pc_write each
//     high for exactly 1 cycle.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multi-cycle main control FSM for the MIPS core: decodes the opcode and
// sequences the datapath one step per clock, stalling on memory accesses.
module mips_mc_control #(
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_wr_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op
);

   typedef enum logic [3:0] {
      ST_RST    = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_MEMADR = 4'd3,
      ST_MEMRD  = 4'd4,
      ST_MEMWB  = 4'd5,
      ST_MEMWR  = 4'd6,
      ST_EXEC   = 4'd7,
      ST_RWB    = 4'd8,
      ST_BRANCH = 4'd9,
      ST_ADDIEX = 4'd10,
      ST_ADDIWB = 4'd11,
      ST_JUMP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t r_state;
   state_t w_nextState;
   logic   w_rdy;

   // Without the handshake every memory access completes in one cycle.
   assign w_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RST;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = ST_FETCH;
      pc_write    = 1'b0;
      pc_wr_cond  = 1'b0;
      i_or_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      mem_to_reg  = 1'b0;
      reg_dst     = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      pc_source   = 2'b00;
      illegal_op  = 1'b0;

      case (r_state)
         ST_RST: begin
            w_nextState = ST_FETCH;
         end
         // IR and PC load only on the cycle the fetch completes.
         ST_FETCH: begin
            mem_read    = 1'b1;
            alu_src_b   = 2'b01;
            ir_write    = w_rdy;
            pc_write    = w_rdy;
            w_nextState = w_rdy ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: w_nextState = ST_MEMADR;
               OP_R:         w_nextState = ST_EXEC;
               OP_BEQ:       w_nextState = ST_BRANCH;
               OP_ADDI:      w_nextState = ST_ADDIEX;
               OP_J:         w_nextState = ST_JUMP;
               default: begin
                  w_nextState = ST_FETCH;
                  illegal_op  = 1'b1;
               end
            endcase
         end
         ST_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (opcode == OP_LW) begin
               w_nextState = ST_MEMRD;
            end else if (opcode == OP_SW) begin
               w_nextState = ST_MEMWR;
            end else begin
               w_nextState = ST_FETCH;
            end
         end
         ST_MEMRD: begin
            mem_read    = 1'b1;
            i_or_d      = 1'b1;
            w_nextState = w_rdy ? ST_MEMWB : ST_MEMRD;
         end
         ST_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            mem_write   = 1'b1;
            i_or_d      = 1'b1;
            w_nextState = w_rdy ? ST_FETCH : ST_MEMWR;
         end
         ST_EXEC: begin
            alu_src_a   = 1'b1;
            alu_op      = 2'b10;
            w_nextState = ST_RWB;
         end
         ST_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_wr_cond = 1'b1;
            pc_source  = 2'b01;
         end
         ST_ADDIEX: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            w_nextState = ST_ADDIWB;
         end
         ST_ADDIWB: begin
            reg_write = 1'b1;
         end
         ST_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         // Unused encodings keep every output low and recover to FETCH.
         default: begin
            w_nextState = ST_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized self-checking bench for mips_mc_control against a per-instruction
// micro-step model derived from the opcode and memory-ready behaviour.
module tb_mips_mc_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWrCond;
      logic       iOrD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memToReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSource;
      logic       illegal;
   } ctl_t;

   typedef struct packed {
      ctl_t c;
      logic waitRdy;
      logic gateFetch;
   } step_t;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_wr_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   ctl_t       actual;

   step_t plan[8];
   int    planLen;
   int    nCmp;
   int    nFail;

   mips_mc_control dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .pc_wr_cond (pc_wr_cond),
      .i_or_d     (i_or_d),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .mem_to_reg (mem_to_reg),
      .reg_dst    (reg_dst),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_source  (pc_source),
      .illegal_op (illegal_op)
   );

   assign actual = {pc_write, pc_wr_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic void addStep(input ctl_t c, input logic w, input logic g);
      step_t s;
      s.c         = c;
      s.waitRdy   = w;
      s.gateFetch = g;
      plan[planLen] = s;
      planLen++;
   endfunction

   // Every instruction is a fetch, a decode, then an opcode-specific tail.
   function automatic void buildPlan(input logic [5:0] op);
      ctl_t c;
      planLen = 0;
      c = '0; c.memRead = 1'b1; c.aluSrcB = 2'b01; c.irWrite = 1'b1; c.pcWrite = 1'b1;
      addStep(c, 1'b1, 1'b1);
      c = '0; c.aluSrcB = 2'b11;
      c.illegal = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
      addStep(c, 1'b0, 1'b0);
      case (op)
         OP_LW, OP_SW: begin
            c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
            addStep(c, 1'b0, 1'b0);
            if (op == OP_LW) begin
               c = '0; c.memRead = 1'b1; c.iOrD = 1'b1;
               addStep(c, 1'b1, 1'b0);
               c = '0; c.regWrite = 1'b1; c.memToReg = 1'b1;
               addStep(c, 1'b0, 1'b0);
            end else begin
               c = '0; c.memWrite = 1'b1; c.iOrD = 1'b1;
               addStep(c, 1'b1, 1'b0);
            end
         end
         OP_R: begin
            c = '0; c.aluSrcA = 1'b1; c.aluOp = 2'b10;
            addStep(c, 1'b0, 1'b0);
            c = '0; c.regWrite = 1'b1; c.regDst = 1'b1;
            addStep(c, 1'b0, 1'b0);
         end
         OP_BEQ: begin
            c = '0; c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.pcWrCond = 1'b1; c.pcSource = 2'b01;
            addStep(c, 1'b0, 1'b0);
         end
         OP_ADDI: begin
            c = '0; c.aluSrcA = 1'b1; c.aluSrcB = 2'b10;
            addStep(c, 1'b0, 1'b0);
            c = '0; c.regWrite = 1'b1;
            addStep(c, 1'b0, 1'b0);
         end
         OP_J: begin
            c = '0; c.pcWrite = 1'b1; c.pcSource = 2'b10;
            addStep(c, 1'b0, 1'b0);
         end
         default: ;
      endcase
   endfunction

   function automatic ctl_t expectCtl(input int k, input logic rdy);
      ctl_t e;
      e = plan[k].c;
      if (plan[k].gateFetch && !rdy) begin
         e.irWrite = 1'b0;
         e.pcWrite = 1'b0;
      end
      return e;
   endfunction

   task automatic tick(input logic rdy, input logic [5:0] op);
      @(negedge clk);
      mem_ready = rdy;
      opcode    = op;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(1'b0, OP_LW);
      nCmp++;
      if (actual !== '0) begin
         nFail++; $display("[TB] FAIL reset_hold actual=%h expected=%h", actual, ctl_t'('0));
      end
      @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; #1;
      nCmp++;
      if (actual !== '0) begin
         nFail++; $display("[TB] FAIL reset_state actual=%h expected=%h", actual, ctl_t'('0));
      end
      buildPlan(OP_LW);
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, OP_LW);
         nCmp++;
         if (actual !== expectCtl(k, 1'b1)) begin
            nFail++; $display("[TB] FAIL reset_lw_step%0d actual=%h expected=%h", k, actual, expectCtl(k, 1'b1));
         end
      end
      tick(1'b0, OP_LW);
      nCmp++;
      if (actual !== expectCtl(3, 1'b0)) begin
         nFail++; $display("[TB] FAIL reset_memrd_stall actual=%h expected=%h", actual, expectCtl(3, 1'b0));
      end
      #2 rst_n = 1'b0;
      #1;
      nCmp++;
      if (actual !== '0) begin
         nFail++; $display("[TB] FAIL async_abort actual=%h expected=%h", actual, ctl_t'('0));
      end
      @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; #1;
      nCmp++;
      if (actual !== '0) begin
         nFail++; $display("[TB] FAIL rst_after_release actual=%h expected=%h", actual, ctl_t'('0));
      end
      tick(1'b0, OP_LW);
      nCmp++;
      if (actual !== expectCtl(0, 1'b0)) begin
         nFail++; $display("[TB] FAIL fetch_after_reset actual=%h expected=%h", actual, expectCtl(0, 1'b0));
      end
   endtask

   task automatic test_rtype();
      int nAlu10 = 0;
      int nRwb = 0;
      buildPlan(OP_R);
      for (int k = 0; k < planLen; k++) begin
         tick(1'b1, OP_R);
         nCmp++;
         if (actual !== expectCtl(k, 1'b1)) begin
            nFail++; $display("[TB] FAIL rtype_step%0d actual=%h expected=%h", k, actual, expectCtl(k, 1'b1));
         end
         if (alu_op === 2'b10) nAlu10++;
         if (reg_write === 1'b1 && reg_dst === 1'b1) nRwb++;
      end
      nCmp++;
      if (nAlu10 != 1) begin
         nFail++; $display("[TB] FAIL rtype_aluop10_cycles actual=%0d expected=1", nAlu10);
      end
      nCmp++;
      if (nRwb != 1) begin
         nFail++; $display("[TB] FAIL rtype_rwb_cycles actual=%0d expected=1", nRwb);
      end
   endtask

   task automatic test_lw_stall();
      int k = 0;
      int stalls = 0;
      int nIorD = 0;
      int nEarlyWr = 0;
      logic rdy;
      buildPlan(OP_LW);
      while (k < planLen) begin
         rdy = !(k == 3 && stalls < 3);
         tick(rdy, OP_LW);
         nCmp++;
         if (actual !== expectCtl(k, rdy)) begin
            nFail++; $display("[TB] FAIL lw_step%0d actual=%h expected=%h", k, actual, expectCtl(k, rdy));
         end
         if (i_or_d === 1'b1) nIorD++;
         if (k < 4 && reg_write !== 1'b0) nEarlyWr++;
         if (!rdy) stalls++;
         else k++;
      end
      nCmp++;
      if (nIorD != 4) begin
         nFail++; $display("[TB] FAIL lw_iord_cycles actual=%0d expected=4", nIorD);
      end
      nCmp++;
      if (nEarlyWr != 0) begin
         nFail++; $display("[TB] FAIL lw_early_regwrite actual=%0d expected=0", nEarlyWr);
      end
   endtask

   task automatic test_beq();
      int nCond = 0;
      int nSub = 0;
      buildPlan(OP_BEQ);
      for (int k = 0; k < planLen; k++) begin
         tick(1'b1, OP_BEQ);
         nCmp++;
         if (actual !== expectCtl(k, 1'b1)) begin
            nFail++; $display("[TB] FAIL beq_step%0d actual=%h expected=%h", k, actual, expectCtl(k, 1'b1));
         end
         if (pc_wr_cond === 1'b1) nCond++;
         if (alu_op === 2'b01) nSub++;
      end
      nCmp++;
      if (nCond != 1 || nSub != 1) begin
         nFail++; $display("[TB] FAIL beq_pulse_cycles actual=%0d/%0d expected=1/1", nCond, nSub);
      end
   endtask

   task automatic test_illegal();
      int nIll = 0;
      int nWr = 0;
      buildPlan(6'b111111);
      for (int k = 0; k < planLen; k++) begin
         tick(1'b1, 6'b111111);
         nCmp++;
         if (actual !== expectCtl(k, 1'b1)) begin
            nFail++; $display("[TB] FAIL illegal_step%0d actual=%h expected=%h", k, actual, expectCtl(k, 1'b1));
         end
         if (illegal_op === 1'b1) nIll++;
         if (reg_write !== 1'b0 || mem_write !== 1'b0) nWr++;
      end
      nCmp++;
      if (nIll != 1 || nWr != 0) begin
         nFail++; $display("[TB] FAIL illegal_pulse actual=%0d/%0d expected=1/0", nIll, nWr);
      end
   endtask

   task automatic test_fetch_stall();
      int k = 0;
      int stalls = 0;
      int nIr = 0;
      int nPc = 0;
      logic rdy;
      buildPlan(OP_ADDI);
      while (k < planLen) begin
         rdy = !(k == 0 && stalls < 2);
         tick(rdy, OP_ADDI);
         nCmp++;
         if (actual !== expectCtl(k, rdy)) begin
            nFail++; $display("[TB] FAIL fetch_stall_step%0d actual=%h expected=%h", k, actual, expectCtl(k, rdy));
         end
         if (ir_write === 1'b1) nIr++;
         if (pc_write === 1'b1) nPc++;
         if (!rdy) stalls++;
         else k++;
      end
      nCmp++;
      if (nIr != 1 || nPc != 1) begin
         nFail++; $display("[TB] FAIL fetch_stall_writes actual=%0d/%0d expected=1/1", nIr, nPc);
      end
   endtask

   task automatic test_random();
      logic [5:0] legalOps[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
      logic [5:0] op;
      logic rdy;
      int k;
      int guard;
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 7) < 7) op = legalOps[$urandom_range(0, 5)];
         else op = 6'($urandom);
         buildPlan(op);
         k = 0;
         guard = 0;
         while (k < planLen && guard < 200) begin
            rdy = ($urandom_range(0, 3) != 0);
            tick(rdy, op);
            guard++;
            nCmp++;
            if (actual !== expectCtl(k, rdy)) begin
               nFail++; $display("[TB] FAIL rand_instr%0d_op%b_step%0d actual=%h expected=%h", n, op, k, actual, expectCtl(k, rdy));
            end
            nCmp++;
            if (alu_op === 2'b11) begin
               nFail++; $display("[TB] FAIL rand_aluop actual=%b expected=not 11", alu_op);
            end
            if (!(plan[k].waitRdy && !rdy)) k++;
         end
         nCmp++;
         if (k < planLen) begin
            nFail++; $display("[TB] FAIL rand_timeout actual=step%0d expected=step%0d", k, planLen);
         end
      end
      buildPlan(OP_R);
      tick(1'b0, OP_R);
      nCmp++;
      if (actual !== expectCtl(0, 1'b0)) begin
         nFail++; $display("[TB] FAIL rand_final_fetch actual=%h expected=%h", actual, expectCtl(0, 1'b0));
      end
   endtask

   initial begin
      nCmp      = 0;
      nFail     = 0;
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      opcode    = 6'b000000;
      test_reset();
      test_rtype();
      test_lw_stall();
      test_beq();
      test_illegal();
      test_fetch_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
